apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_pkg.sv | 15 +
 rtl/apb_master_bridge.sv | 147 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge.
// Holds the FSM state encoding, the APB data width and the default
// ACCESS-phase timeout used when APB_MASTER_TIMEOUT_EN is defined.
package apb_master_pkg;

    localparam int APB_DATA_WIDTH      = 32;
    localparam int APB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding core-request to APB master bridge.
// One request is accepted in IDLE, driven through SETUP and ACCESS, and its
// completion is reported with a one-cycle rvalid_o pulse the cycle after the
// slave signals PREADY.  Optional macro APB_MASTER_TIMEOUT_EN adds an
// ACCESS-phase watchdog that ends a stuck transfer with err_o=1.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
    input  logic                      HCLK,
    input  logic                      HRESET,

    // core side
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    input  logic                      we_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,

    // APB side
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // The watchdog counter is 16 bits wide, so the limit must fit it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end

    apb_mst_state_e state_q, state_d;

    logic slave_done;   // ACCESS cycle in which the slave completes
    logic timeout_hit;  // ACCESS cycle in which the watchdog gives up
    logic complete;     // transfer ends this cycle, report next cycle

    assign slave_done = (state_q == ACCESS) && PREADY;
    assign complete   = slave_done || timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_q;

    // Watchdog: zeroed while in SETUP so it reads 0 in the first ACCESS
    // cycle, then counts every ACCESS cycle the slave is still stalling.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            to_cnt_q <= 16'd0;
        end else if (state_q == SETUP) begin
            to_cnt_q <= 16'd0;
        end else if (state_q == ACCESS && !PREADY) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    // PREADY in the final allowed cycle wins over the timeout.
    assign timeout_hit = (state_q == ACCESS) && !PREADY && (to_cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SETUP on grant, SETUP -> ACCESS always,
    // ACCESS -> IDLE once the slave finishes or the watchdog fires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i)    state_d = SETUP;
            SETUP:                 state_d = ACCESS;
            ACCESS:  if (complete) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Output decode: handshake and APB phase strobes follow the state.
    always_comb begin
        gnt_o   = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_o = req_i;
            end
            SETUP: begin
                PSEL = 1'b1;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            default: begin
                gnt_o = 1'b0;
            end
        endcase
    end

    // Request capture: the address/data/direction are latched only on grant,
    // so they stay frozen for the whole SETUP+ACCESS window regardless of
    // what the core does meanwhile.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
        end else if (gnt_o) begin
            PADDR  <= addr_i;
            PWDATA <= wdata_i;
            PWRITE <= we_i;
        end
    end

    // Completion report: one-cycle rvalid_o pulse; rdata_o/err_o update only
    // on completion and otherwise keep the previous result.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= complete;
            if (complete) begin
                rdata_o <= (slave_done && !PWRITE) ? PRDATA : '0;
                err_o   <= slave_done ? PSLVERR : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized scoreboard bench for apb_master_bridge.
// Stimulus pushes each accepted request into a slave queue and its expected
// response (data, error, completion cycle) into a scoreboard queue; a slave
// model and a response monitor consume those queues independently.
// Build with APB_MASTER_TIMEOUT_EN defined to also exercise the watchdog.
module tb_apb_master_bridge;
    import apb_master_pkg::*;

    localparam int AW = 12;
    localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          req_i, we_i, gnt_o, rvalid_o, err_o;
    logic [AW-1:0] addr_i, PADDR;
    logic [31:0]   wdata_i, rdata_o, PWDATA, PRDATA;
    logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    apb_master_bridge #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          we;
        int            w;       // wait states the slave inserts
        logic [31:0]   prdata;
        logic          slverr;
    } xfer_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;        // cycle in which rvalid_o must be seen
    } resp_t;

    xfer_t sq[$];
    resp_t sb[$];
    int checks = 0;
    int errors = 0;
    int next_free = 0;          // first cycle in which a grant is possible

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bool_t_dummy(input int x);
        return x;
    endfunction

    function automatic bit times_out(input int w);
        return TO_EN && (w >= TO);
    endfunction

    function automatic xfer_t mk(input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic we, input int w,
                                 input logic [31:0] prd, input logic se);
        xfer_t x;
        x.addr = a; x.wdata = d; x.we = we; x.w = w; x.prdata = prd; x.slverr = se;
        return x;
    endfunction

    function automatic xfer_t rnd(input int w);
        return mk(AW'($urandom), $urandom, 1'($urandom), w, $urandom, 1'($urandom));
    endfunction

    // Present one request until granted; predicts when a grant is legal.
    task automatic do_xfer(input xfer_t x);
        int  tries = 0;
        bit  done  = 0;
        resp_t e;
        while (!done) begin
            @(posedge HCLK); #1;
            req_i = 1'b1; addr_i = x.addr; wdata_i = x.wdata; we_i = x.we;
            #1;
            check("gnt", 64'(gnt_o), 64'(cyc >= next_free));
            if (gnt_o) begin
                sq.push_back(x);
                if (times_out(x.w)) begin
                    e.rdata = 32'h0; e.err = 1'b1; e.at = cyc + 2 + TO;
                end else begin
                    e.rdata = x.we ? 32'h0 : x.prdata; e.err = x.slverr; e.at = cyc + 3 + x.w;
                end
                sb.push_back(e);
                next_free = e.at;
                done = 1;
            end else if (++tries > 40) begin
                errors++;
                $display("FAIL gnt_wait: got no grant, expected one within 40 cycles");
                done = 1;
            end
        end
    endtask

    // Idle cycles with junk on the request fields; no grant may appear.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK); #1;
            req_i = 1'b0; addr_i = AW'($urandom); wdata_i = $urandom; we_i = 1'($urandom);
            #1;
            check("gnt_idle", 64'(gnt_o), 64'(0));
        end
    endtask

    // APB slave model: answers after the configured wait states and checks
    // the request fields and the length of the SETUP/ACCESS window.
    initial begin
        xfer_t cur;
        int    k = 0, ps = 0, pe = 0;
        bit    act = 0;
        PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                act = 0; PREADY = 1'b0;
            end else if (PSEL && !PENABLE) begin
                if (sq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL setup_unrequested: got PSEL=1, expected 0");
                end else begin
                    cur = sq.pop_front();
                    act = 1; k = 0; ps = 1; pe = 0;
                    check("setup_paddr", 64'(PADDR), 64'(cur.addr));
                    check("setup_pwdata", 64'(PWDATA), 64'(cur.wdata));
                    check("setup_pwrite", 64'(PWRITE), 64'(cur.we));
                end
                PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
            end else if (PSEL && PENABLE && act) begin
                ps++; pe++;
                check("access_paddr", 64'(PADDR), 64'(cur.addr));
                check("access_pwdata", 64'(PWDATA), 64'(cur.wdata));
                check("access_pwrite", 64'(PWRITE), 64'(cur.we));
                if (k == cur.w) begin
                    PREADY = 1'b1; PRDATA = cur.prdata; PSLVERR = cur.slverr;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
                end
                k++;
            end else begin
                if (act) begin
                    check("psel_cycles", 64'(ps), 64'(times_out(cur.w) ? 1 + TO : 2 + cur.w));
                    check("penable_cycles", 64'(pe), 64'(times_out(cur.w) ? TO : 1 + cur.w));
                    act = 0;
                end
                PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
        end
    end

    // Response monitor: pops the scoreboard on rvalid_o, otherwise checks
    // that the last result is held.
    initial begin
        resp_t       e;
        logic [31:0] hr = 32'h0;
        logic        he = 1'b0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                hr = 32'h0; he = 1'b0;
            end else if (rvalid_o) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid: got rvalid_o=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("rvalid_cycle", 64'(cyc), 64'(e.at));
                    check("rdata", 64'(rdata_o), 64'(e.rdata));
                    check("err", 64'(err_o), 64'(e.err));
                    hr = e.rdata; he = e.err;
                end
            end else begin
                check("rdata_hold", 64'(rdata_o), 64'(hr));
                check("err_hold", 64'(err_o), 64'(he));
            end
        end
    end

    initial begin
        xfer_t x;
        int    n;
        HRESET = 1'b1; req_i = 1'b0; addr_i = '0; wdata_i = '0; we_i = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        #1;
        check("rst_psel", 64'(PSEL), 64'(0));
        check("rst_penable", 64'(PENABLE), 64'(0));
        check("rst_pwrite", 64'(PWRITE), 64'(0));
        check("rst_paddr", 64'(PADDR), 64'(0));
        check("rst_pwdata", 64'(PWDATA), 64'(0));
        check("rst_rvalid", 64'(rvalid_o), 64'(0));
        check("rst_rdata", 64'(rdata_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        next_free = cyc;

        // read, zero wait states
        do_xfer(mk(12'h008, 32'h0, 1'b0, 0, 32'hDEADBEEF, 1'b0));
        idle(2);
        // write with 4 wait states
        do_xfer(mk(12'h3C4, 32'h0000_00A5, 1'b1, 4, 32'h1234_5678, 1'b0));
        idle(1);
        // read with slave error
        do_xfer(mk(12'h010, 32'h0, 1'b0, 1, 32'hCAFE_F00D, 1'b1));
        idle(1);
        // three back-to-back transfers with req_i held high
        for (int i = 0; i < 3; i++) do_xfer(rnd(0));
        idle(2);
        // long stall (watchdog case when enabled), then PREADY in the last allowed cycle
        do_xfer(mk(12'h020, 32'h0, 1'b0, TO + 6, 32'h5555_AAAA, 1'b0));
        idle(1);
        do_xfer(mk(12'h024, 32'h0, 1'b0, TO - 1, 32'h0BAD_C0DE, 1'b0));
        idle(1);

        // reset in the middle of ACCESS aborts the transfer silently
        do_xfer(mk(12'h030, 32'h0, 1'b0, 5, 32'h7777_7777, 1'b0));
        n = 0;
        do begin
            @(posedge HCLK); #1 req_i = 1'b0; #1;
            n++;
        end while (!PENABLE && n < 10);
        check("reach_access", 64'(PENABLE), 64'(1));
        HRESET = 1'b1;
        @(posedge HCLK); #1 HRESET = 1'b0;
        sq.delete(); sb.delete();
        next_free = cyc;
        #1;
        check("abort_psel", 64'(PSEL), 64'(0));
        check("abort_rvalid", 64'(rvalid_o), 64'(0));
        idle(8);
        do_xfer(mk(12'h040, 32'h0, 1'b0, 0, 32'h0A0B_0C0D, 1'b0));
        idle(1);

        // randomized traffic, gaps of 0 give back-to-back requests
        for (int i = 0; i < 40; i++) begin
            x = rnd($urandom_range(0, 6));
            do_xfer(x);
            n = $urandom_range(0, 2);
            if (n > 0) idle(n);
        end

        n = 0;
        while (sb.size() > 0 && n < 80) begin
            idle(1);
            n++;
        end
        check("drain", 64'(sb.size()), 64'(0));
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
